// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states, byte lanes and access checks
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             accept;
    logic             req_err;
    logic             mem_we;
    logic [3:0]       lane_en;
    logic [31:0]      lane_data;
    logic [31:0]      word_rd;
    logic [31:0]      shifted;
    logic [31:0]      load_data;
    logic [IDX_W-1:0] word_idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign word_idx = req_addr[IDX_W+1:2];
    assign accept   = (state == IDLE) && req_valid;
    // rst must also block the write, since the array itself is never reset
    assign mem_we   = accept && req_we && !req_err && !rst;

    always_comb begin
        req_err   = 1'b0;
        lane_en   = 4'b0000;
        lane_data = 32'h0;
        case (req_size)
            2'b00: begin
                lane_en   = 4'b0001 << req_addr[1:0];
                lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_err   = req_addr[0];
                lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                req_err   = (req_addr[1:0] != 2'b00);
                lane_en   = 4'b1111;
                lane_data = req_wdata;
            end
            default: req_err = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        word_rd   = mem[word_idx];
        shifted   = word_rd >> {req_addr[1:0], 3'b000};
        load_data = 32'h0;
        case (req_size)
            2'b00:   load_data = {24'h0, shifted[7:0]};
            2'b01:   load_data = {16'h0, shifted[15:0]};
            2'b10:   load_data = word_rd;
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                rsp_err   <= req_err;
                rsp_rdata <= (req_we || req_err) ? 32'h0 : load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

endmodule
